// File: rtl/mask_morph_pkg.sv
// Shared defaults, filter-mode and FSM-state encodings, and the 3x3 morphology helper for mask_morph.
package mask_morph_pkg;

  localparam int DEF_WIDTH  = 800;
  localparam int DEF_HEIGHT = 600;

  typedef enum logic [1:0] {
    MODE_BYPASS   = 2'b00,
    MODE_ERODE    = 2'b01,
    MODE_DILATE   = 2'b10,
    MODE_MAJORITY = 2'b11
  } mode_t;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_FILL  = 2'd1;
  localparam state_t S_RUN   = 2'd2;
  localparam state_t S_FLUSH = 2'd3;

  // win[4] is the window centre; bit order is otherwise irrelevant to every mode.
  function automatic logic morph_filter(input logic [8:0] win, input mode_t mode);
    logic [3:0] ones;
    logic       res;
    ones = '0;
    for (int i = 0; i < 9; i++) ones = ones + {3'b000, win[i]};
    case (mode)
      MODE_ERODE:    res = &win;
      MODE_DILATE:   res = |win;
      MODE_MAJORITY: res = (ones >= 4'd5);
      default:       res = win[4];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mask_morph_delay_line.sv
// Circular-buffer delay of DEPTH enabled samples; dout is the sample written DEPTH enables ago.
module morph_delay_line #(
  parameter int DEPTH = 8,
  parameter int DW    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;

  // Read-before-write at the same slot gives exactly DEPTH samples of latency.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= '0;
    else if (en) ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

endmodule

// File: rtl/mask_morph.sv
// 3x3 binary morphology on a foreground mask with RGB compositing against a background.
// Optional per-frame foreground statistics are built when MASK_MORPH_STATS_EN is defined.
module mask_morph
  import mask_morph_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic        i_mask,
  input  logic [23:0] i_pix_rgb,
  input  logic [23:0] i_bg_rgb,
  input  logic [1:0]  i_mode,
  input  logic        VS_negedge,
  output logic        o_valid,
  output logic        o_mask_f,
  output logic [23:0] o_rgb,
  output logic [19:0] o_fg_count,
  output logic [1:0]  fsm_state
);

  // Strobe semantics: i_valid is a one-cycle pixel strobe with no backpressure; every
  // strobe is consumed. o_valid is a one-cycle strobe qualifying o_mask_f/o_rgb.
  localparam int CW  = $clog2(WIDTH * HEIGHT + 1);
  localparam int CLW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0]  CNT_W    = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH * HEIGHT - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(WIDTH - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(HEIGHT - 1);

  state_t         state;
  mode_t          mode_q;
  logic [CW-1:0]  cnt;
  logic [CLW-1:0] col;
  logic [RW-1:0]  row;

  logic        adv;
  logic        emit;
  logic        d1_out;
  logic        d2_out;
  logic [47:0] rgb_out;
  logic [1:0]  r0, r1, r2;
  logic [2:0]  w0, w1, w2;
  logic        border;
  logic        filt;

  assign fsm_state = state;

  // The delays run on every strobe, plus every cycle of the flush; a restarting frame's
  // first pixel also advances them.
  assign adv  = VS_negedge ? i_valid : (i_valid || state == S_FLUSH);
  assign emit = !VS_negedge && ((state == S_RUN && i_valid) || state == S_FLUSH);

  morph_delay_line #(.DEPTH(WIDTH), .DW(1)) u_line1 (
    .clk(clk), .rst_n(rst_n), .en(adv), .din(i_mask), .dout(d1_out)
  );

  morph_delay_line #(.DEPTH(WIDTH), .DW(1)) u_line2 (
    .clk(clk), .rst_n(rst_n), .en(adv), .din(d1_out), .dout(d2_out)
  );

  morph_delay_line #(.DEPTH(WIDTH + 1), .DW(48)) u_rgb (
    .clk(clk), .rst_n(rst_n), .en(adv), .din({i_pix_rgb, i_bg_rgb}), .dout(rgb_out)
  );

  // Window including the sample arriving this cycle, so the output registers one cycle after its strobe.
  assign w0 = {r0, i_mask};
  assign w1 = {r1, d1_out};
  assign w2 = {r2, d2_out};

  always_ff @(posedge clk) begin
    if (adv) begin
      r0 <= w0[1:0];
      r1 <= w1[1:0];
      r2 <= w2[1:0];
    end
  end

  assign border = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
  assign filt   = border ? w1[1] : morph_filter({w2, w1, w0}, mode_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mode_q   <= MODE_BYPASS;
      cnt      <= '0;
      col      <= '0;
      row      <= '0;
      o_valid  <= 1'b0;
      o_mask_f <= 1'b0;
      o_rgb    <= '0;
    end else begin
      o_valid <= emit;
      if (emit) begin
        o_mask_f <= filt;
        o_rgb    <= filt ? rgb_out[47:24] : rgb_out[23:0];
        if (col == COL_LAST) begin
          col <= '0;
          if (row != ROW_LAST) row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (VS_negedge) begin
        mode_q <= mode_t'(i_mode);
        cnt    <= i_valid ? CW'(1) : '0;
        col    <= '0;
        row    <= '0;
        state  <= i_valid ? S_FILL : S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (i_valid) begin
            state <= S_FILL;
            cnt   <= CW'(1);
            col   <= '0;
            row   <= '0;
          end
          S_FILL: if (i_valid) begin
            if (cnt == CNT_W) state <= S_RUN;
            cnt <= cnt + 1'b1;
          end
          S_RUN: if (i_valid) begin
            if (cnt == CNT_LAST) begin
              state <= S_FLUSH;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            if (cnt == CNT_W) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef MASK_MORPH_STATS_EN
  logic [19:0] fg_cnt;

  // Published only when a frame flushes to completion; an aborted frame leaves the last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fg_cnt     <= '0;
      o_fg_count <= '0;
    end else if (VS_negedge || (state == S_IDLE && i_valid)) begin
      fg_cnt <= '0;
    end else if (emit) begin
      if (state == S_FLUSH && cnt == CNT_W) begin
        o_fg_count <= fg_cnt + {19'd0, filt};
        fg_cnt     <= '0;
      end else begin
        fg_cnt <= fg_cnt + {19'd0, filt};
      end
    end
  end
`else
  assign o_fg_count = '0;
`endif

endmodule
